// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sequencer sharing one fixed-latency multiplier between two requesters
module mul_arbiter #(
  parameter int WIDTH   = 16,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_a,
  input  logic [WIDTH-1:0]     req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_a,
  input  logic [WIDTH-1:0]     req1_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_hi_nz,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 busy
);

  localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cnt;
  logic           owner;
  logic           last_grant;
  logic           grant;
  logic           accept;
  logic           rsp_hs;

  // Ties go to the requester that was not served last; a lone request always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept = (state == IDLE) && (req0_valid || req1_valid);
  assign rsp_hs = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && req0_valid && !grant;
    req1_ready = (state == IDLE) && req1_valid && grant;
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) && owner;
    busy       = (state != IDLE);
  end

  // Operands stay parked on mul_a/mul_b until the next accept so the multiplier sees them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      rsp_result <= '0;
      rsp_hi_nz  <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      if (accept) begin
        mul_a      <= grant ? req1_a : req0_a;
        mul_b      <= grant ? req1_b : req0_b;
        owner      <= grant;
        last_grant <= grant;
        cnt        <= CW'(MUL_LAT);
      end
      if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          rsp_result <= mul_result;
          rsp_hi_nz  <= |mul_result[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Sequencer and round-robin arbiter that shares one multiplier between two requesters in the 16-bit RISC core. Requester 0 is the execute-stage ALU issue and requester 1 is the address/MAC helper. The block accepts one operation at a time over valid/ready handshakes and drives the operands to the external multiplier. It waits a fixed multiplier latency, captures the double-width product, and returns it to the originating requester with an upper-half-nonzero flag.

## Interface
Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH.
- MUL_LAT, 2, multiplier latency in cycles from stable operands to valid product (0 = combinational).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid
- req0_a, req0_b  in  WIDTH  requester 0 operands (unsigned)
- req1_valid, req1_ready, req1_a, req1_b  same as above for requester 1
- rsp0_valid  out  1  product available for requester 0
- rsp0_ready  in  1  requester 0 consumes product
- rsp1_valid, rsp1_ready  same for requester 1
- rsp_result  out  2*WIDTH  captured product, shared by both response channels
- rsp_hi_nz  out  1  rsp_result[2*WIDTH-1:WIDTH] != 0
- mul_a, mul_b  out  WIDTH  operands to the shared multiplier (registered)
- mul_result  in  2*WIDTH  multiplier product
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WAIT, RESP. Reset goes to IDLE.
- Reset values:
  - all ready and valid outputs 0
  - busy 0
  - mul_a, mul_b, rsp_result 0
  - rsp_hi_nz 0
  - owner 0
  - last_grant = 1, so requester 0 wins the first tie.
- Arbitration applies in IDLE only and is combinational:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) & grant==N. At most one ready is high; ready is 0 outside IDLE.
- On accept (reqN_valid & reqN_ready):
  - mul_a/mul_b <= reqN_a/reqN_b
  - owner <= N, last_grant <= N
  - cnt <= MUL_LAT
  - state -> WAIT
- WAIT:
  - mul_a/mul_b are held constant.
  - If cnt != 0, cnt decrements.
  - If cnt == 0: rsp_result <= mul_result, rsp_hi_nz <= (mul_result upper half != 0), state -> RESP.
- RESP:
  - rsp{owner}_valid = 1; the other rsp valid stays 0.
  - rsp_result and rsp_hi_nz are held until rsp{owner}_ready.
  - Handshake edge -> IDLE.
  - rspN_ready while not valid is ignored.
- Requesters hold valid and operands until ready. The block never drops an accepted operation.
- A new request cannot be accepted in the cycle the response handshake completes; it is accepted from the next IDLE cycle.
- Products are unsigned full width. There is no truncation, and rsp_hi_nz signals that the result does not fit in WIDTH.

## Timing
- Accept at edge T. Operands are on mul_a/mul_b from cycle T+1.
- Product is sampled at the end of cycle T+1+MUL_LAT. rsp valid rises at cycle T+2+MUL_LAT.
- Minimum occupancy with rsp_ready tied high: MUL_LAT+3 cycles per operation (accept, MUL_LAT+1 WAIT cycles, RESP).
- busy is high from T+1 through the RESP cycle inclusive.
- Back-to-back contention: with both valid held continuously, grants alternate 0,1,0,1.
- rst asserted in any state:
  - next edge forces IDLE and all reset values; any in-flight or pending product is discarded.
  - no rsp valid pulses in the cycle after reset.
- Response backpressure: RESP may persist indefinitely, and no request is accepted during it.

## Test plan
- Single op, WIDTH=16, MUL_LAT=2, rsp ready high: req0 a=0x0003 b=0x0005 accepted at cycle 1 -> rsp0_valid in cycle 5 only, rsp_result=0x0000000F, rsp_hi_nz=0, rsp1_valid never high.
- Overflow: req1 a=0xFFFF b=0xFFFF -> rsp1_valid with rsp_result=0xFFFE0001, rsp_hi_nz=1.
- Contention: both valid continuously from reset with distinct operands (req0 2*3, req1 4*5) -> first grant to 0, then 1, then 0. Responses 6, 20, 6 are returned on the matching channel, one op per 5 cycles.
- Backpressure: rsp0_ready low for 10 cycles in RESP -> rsp0_valid and rsp_result stable, req1_ready stays 0 despite req1_valid, busy=1. Response completes on the ready edge; req1 is accepted the following cycle.
- Reset mid-op: rst pulsed during WAIT -> next cycle all outputs 0 and state IDLE, no response ever emitted for the aborted op. The next req0 is granted first.
- MUL_LAT=0 build: req0 7*9 -> rsp0_valid two cycles after accept, rsp_result=63.
